// File: rtl/lif_host_pkg.sv
// Shared state encoding and constants for the LIF neuron host sequencer.
package lif_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_GAP   = 3'd2,
    ST_PARAM = 3'd3,
    ST_SETUP = 3'd4,
    ST_RUN   = 3'd5
  } state_t;

  localparam logic [1:0] PW_E_REST = 2'd0;
  localparam logic [1:0] PW_E_TAU  = 2'd1;
  localparam logic [1:0] PW_V_TH   = 2'd2;
  localparam int         N_PARAM   = 3;

  localparam int DEF_PIPE_LAT = 9;
  localparam int DEF_N_INIT   = 8;

endpackage

// File: rtl/lif_out_decoder.sv
// Neuron output capture: RUN latency counter, v_out/spike unpack and a
// saturating spike counter.
module lif_out_decoder
  import lif_host_pkg::*;
#(
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int SPK_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic             run_next,
  input  logic [7:0]       nrn_uo_out,
  input  logic [7:0]       nrn_uio_out,
  input  logic [7:0]       nrn_uio_oe,
  output logic             v_valid,
  output logic [15:0]      v_out,
  output logic             spike,
  output logic [SPK_W-1:0] spike_count
);

  localparam int              LW      = $clog2(PIPE_LAT + 1);
  localparam logic [LW-1:0]    LAT_MAX = '1;
  localparam logic [LW-1:0]    LAT_GO  = LW'(PIPE_LAT - 1);
  localparam logic [SPK_W-1:0] CNT_MAX = '1;

  logic [LW-1:0] lat_cnt;
  logic          capture;
  logic          unused_oe;

  // Capture only while the FSM stays in RUN, so a stop drops v_valid at once.
  assign capture   = run & run_next & (lat_cnt >= LAT_GO) & nrn_uio_oe[0];
  assign unused_oe = ^nrn_uio_oe[7:1];

  // Cycles spent in RUN since entry; holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt <= '0;
    end else if (!run) begin
      lat_cnt <= '0;
    end else if (lat_cnt != LAT_MAX) begin
      lat_cnt <= lat_cnt + LW'(1);
    end else begin
      lat_cnt <= lat_cnt;
    end
  end

  // Registered neuron outputs and spike tally.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_valid     <= 1'b0;
      v_out       <= 16'h0000;
      spike       <= 1'b0;
      spike_count <= '0;
    end else begin
      v_valid <= capture;
      v_out   <= capture ? {nrn_uo_out, nrn_uio_out[7:1], 1'b0} : 16'h0000;
      spike   <= capture & nrn_uio_out[0];
      if (clear) begin
        spike_count <= '0;
      end else if (capture && nrn_uio_out[0] && (spike_count != CNT_MAX)) begin
        spike_count <= spike_count + SPK_W'(1);
      end else begin
        spike_count <= spike_count;
      end
    end
  end

endmodule

// File: rtl/lif_host_sequencer.sv
// Host-side sequencer for the LIF neuron pin protocol: reset, parameter and
// initial-V load, then current streaming with decoded neuron outputs.
module lif_host_sequencer
  import lif_host_pkg::*;
#(
  parameter int N_INIT   = DEF_N_INIT,
  parameter int PAR_GAP  = 2,
  parameter int RST_CYC  = 2,
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int SPK_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [15:0]      cfg_e_rest,
  input  logic [15:0]      cfg_e_tau,
  input  logic [15:0]      cfg_v_th,
  input  logic             init_valid,
  input  logic [15:0]      init_data,
  output logic             init_ready,
  input  logic             cur_valid,
  input  logic [7:0]       cur_data,
  output logic             cur_ready,
  output logic             nrn_rst,
  output logic [7:0]       nrn_ui_in,
  output logic [7:0]       nrn_uio_in,
  input  logic [7:0]       nrn_uo_out,
  input  logic [7:0]       nrn_uio_out,
  input  logic [7:0]       nrn_uio_oe,
  output logic             v_valid,
  output logic [15:0]      v_out,
  output logic             spike,
  output logic [SPK_W-1:0] spike_count,
  output logic             busy,
  output logic             init_err
);

  localparam logic [7:0] STEP_MAX = 8'hFF;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  step;
  logic [7:0]  step_nx;
  logic [15:0] e_rest_q;
  logic [15:0] e_tau_q;
  logic [15:0] v_th_q;
  logic        nrn_rst_nx;
  logic [15:0] bus_nx;
  logic        init_err_nx;
  logic        go;

  assign go = (state == ST_IDLE) & start;

  // Next-state and per-state step counter.
  always_comb begin
    state_nx = state;
    step_nx  = (step == STEP_MAX) ? step : step + 8'd1;
    case (state)
      ST_IDLE: begin
        step_nx = 8'd0;
        if (start) state_nx = ST_RESET;
        else       state_nx = ST_IDLE;
      end
      ST_RESET: begin
        if (step == 8'(RST_CYC - 1)) begin
          state_nx = ST_GAP;
          step_nx  = 8'd0;
        end else begin
          state_nx = ST_RESET;
        end
      end
      ST_GAP: begin
        if (step == 8'(PAR_GAP - 1)) begin
          state_nx = ST_PARAM;
          step_nx  = 8'd0;
        end else begin
          state_nx = ST_GAP;
        end
      end
      ST_PARAM: begin
        if (step == 8'(N_PARAM - 1)) begin
          state_nx = ST_SETUP;
          step_nx  = 8'd0;
        end else begin
          state_nx = ST_PARAM;
        end
      end
      ST_SETUP: begin
        if (step == 8'(N_INIT - 1)) begin
          state_nx = ST_RUN;
          step_nx  = 8'd0;
        end else begin
          state_nx = ST_SETUP;
        end
      end
      ST_RUN: begin
        step_nx = 8'd0;
        if (stop) state_nx = ST_IDLE;
        else      state_nx = ST_RUN;
      end
      default: begin
        state_nx = ST_IDLE;
        step_nx  = 8'd0;
      end
    endcase
  end

  // Pin values for the next cycle; leaving for IDLE parks the neuron at once.
  always_comb begin
    nrn_rst_nx  = 1'b0;
    bus_nx      = 16'h0000;
    init_err_nx = go ? 1'b0 : init_err;
    if (state_nx == ST_IDLE) begin
      nrn_rst_nx = 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_RESET: nrn_rst_nx = 1'b1;
        ST_GAP:            bus_nx = 16'h0000;
        ST_PARAM: begin
          case (step[1:0])
            PW_E_REST: bus_nx = e_rest_q;
            PW_E_TAU:  bus_nx = e_tau_q;
            PW_V_TH:   bus_nx = v_th_q;
            default:   bus_nx = 16'h0000;
          endcase
        end
        ST_SETUP: begin
          if (init_valid) begin
            bus_nx = init_data;
          end else begin
            bus_nx      = 16'h0000;
            init_err_nx = 1'b1;
          end
        end
        ST_RUN:  bus_nx = {(cur_valid ? cur_data : 8'h00), 8'h00};
        default: nrn_rst_nx = 1'b1;
      endcase
    end
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      step       <= 8'd0;
      e_rest_q   <= 16'h0000;
      e_tau_q    <= 16'h0000;
      v_th_q     <= 16'h0000;
      nrn_rst    <= 1'b1;
      nrn_ui_in  <= 8'h00;
      nrn_uio_in <= 8'h00;
      init_ready <= 1'b0;
      cur_ready  <= 1'b0;
      busy       <= 1'b0;
      init_err   <= 1'b0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
      if (go) begin
        e_rest_q <= cfg_e_rest;
        e_tau_q  <= cfg_e_tau;
        v_th_q   <= cfg_v_th;
      end else begin
        e_rest_q <= e_rest_q;
        e_tau_q  <= e_tau_q;
        v_th_q   <= v_th_q;
      end
      nrn_rst    <= nrn_rst_nx;
      nrn_ui_in  <= bus_nx[15:8];
      nrn_uio_in <= bus_nx[7:0];
      init_ready <= (state_nx == ST_SETUP);
      cur_ready  <= (state_nx == ST_RUN);
      busy       <= (state_nx != ST_IDLE);
      init_err   <= init_err_nx;
    end
  end

  lif_out_decoder #(
    .PIPE_LAT (PIPE_LAT),
    .SPK_W    (SPK_W)
  ) u_dec (
    .clk         (clk),
    .rst         (rst),
    .clear       (go),
    .run         (state == ST_RUN),
    .run_next    (state_nx == ST_RUN),
    .nrn_uo_out  (nrn_uo_out),
    .nrn_uio_out (nrn_uio_out),
    .nrn_uio_oe  (nrn_uio_oe),
    .v_valid     (v_valid),
    .v_out       (v_out),
    .spike       (spike),
    .spike_count (spike_count)
  );

endmodule

// File: tb/tb_lif_host_sequencer.sv
// Directed/randomized bench: a cycle-level protocol model plus a behavioural
// neuron paired with the sequencer; every output is checked every cycle.
module tb_lif_host_sequencer;

  localparam int N_INIT   = 8;
  localparam int PAR_GAP  = 2;
  localparam int RST_CYC  = 2;
  localparam int PIPE_LAT = 9;
  // Narrow counter so saturation is reachable in a short run.
  localparam int SPK_W    = 6;
  localparam int CMAX     = (1 << SPK_W) - 1;

  // Cycle numbers relative to the start edge (state view).
  localparam int T_GAP   = 1 + RST_CYC;
  localparam int T_PARAM = T_GAP + PAR_GAP;
  localparam int T_SETUP = T_PARAM + 3;
  localparam int T_RUN   = T_SETUP + N_INIT;

  logic clk, rst, start, stop;
  logic [15:0] cfg_e_rest, cfg_e_tau, cfg_v_th;
  logic init_valid, init_ready, cur_valid, cur_ready;
  logic [15:0] init_data;
  logic [7:0] cur_data, nrn_ui_in, nrn_uio_in, nrn_uo_out, nrn_uio_out, nrn_uio_oe;
  logic nrn_rst, v_valid, spike, busy, init_err;
  logic [15:0] v_out;
  logic [SPK_W-1:0] spike_count;

  lif_host_sequencer #(
    .N_INIT(N_INIT), .PAR_GAP(PAR_GAP), .RST_CYC(RST_CYC),
    .PIPE_LAT(PIPE_LAT), .SPK_W(SPK_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_e_rest(cfg_e_rest), .cfg_e_tau(cfg_e_tau), .cfg_v_th(cfg_v_th),
    .init_valid(init_valid), .init_data(init_data), .init_ready(init_ready),
    .cur_valid(cur_valid), .cur_data(cur_data), .cur_ready(cur_ready),
    .nrn_rst(nrn_rst), .nrn_ui_in(nrn_ui_in), .nrn_uio_in(nrn_uio_in),
    .nrn_uo_out(nrn_uo_out), .nrn_uio_out(nrn_uio_out), .nrn_uio_oe(nrn_uio_oe),
    .v_valid(v_valid), .v_out(v_out), .spike(spike), .spike_count(spike_count),
    .busy(busy), .init_err(init_err)
  );

  always #5 clk = ~clk;

  int n_cmp, n_bad, cyc;
  // Protocol model
  bit act, ierr;
  int rel, cnt;
  logic [15:0] cfg_m [3];
  // Stimulus knobs
  int drop_idx;
  bit force_ff, kill_oe;
  // Neuron model
  int nw;
  logic [15:0] prm [3];
  logic [15:0] vq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic neuron(input logic e_rst, input logic [7:0] e_ui, input logic [7:0] e_uio);
    logic [15:0] w, old, vw;
    int v;
    bit spk;
    w = {e_ui, e_uio};
    if (e_rst) begin
      nw = 0;
      vq.delete();
      nrn_uo_out = 8'h00; nrn_uio_out = 8'h00; nrn_uio_oe = 8'h00;
    end else begin
      if (nw >= PAR_GAP && nw < PAR_GAP + 3) begin
        prm[nw - PAR_GAP] = w;
      end else if (nw >= PAR_GAP + 3 && nw < PAR_GAP + 3 + N_INIT) begin
        vq.push_back(w);
      end else if (nw >= PAR_GAP + 3 + N_INIT) begin
        old = vq.pop_front();
        v = int'($signed(old)) + int'(e_ui) * 16;
        if (v > 32767) v = 32767;
        spk = (v >= int'($signed(prm[2])));
        if (spk) v = int'($signed(prm[0]));
        vw = 16'(v);
        vq.push_back(vw);
        nrn_uo_out  = vw[15:8];
        nrn_uio_out = {vw[7:1], spk};
        nrn_uio_oe  = kill_oe ? 8'h00 : 8'h01;
      end
      if (nw < 100000) nw++;
    end
  endtask

  task automatic drive();
    start = 1'b0; stop = 1'b0; rst = 1'b0;
    if (act && rel >= T_SETUP && rel < T_RUN) begin
      init_data  = 16'(rel - T_SETUP + 1);
      init_valid = ((rel - T_SETUP) != drop_idx);
    end else begin
      init_data  = 16'($urandom);
      init_valid = 1'($urandom);
    end
    cur_valid = force_ff ? 1'b1 : ($urandom_range(0, 3) != 0);
    cur_data  = force_ff ? 8'hFF : 8'($urandom);
    if (act) begin
      cfg_e_rest = 16'($urandom); cfg_e_tau = 16'($urandom); cfg_v_th = 16'($urandom);
    end
  endtask

  task automatic tick();
    logic a_rst, a_start, a_stop, a_iv, a_cv;
    logic [15:0] a_id, a_er, a_et, a_vt, e_vo;
    logic [7:0] a_cd, a_uo, a_uio, a_oe, e_ui, e_uio;
    logic e_rst, e_vv, e_spk;
    a_rst = rst; a_start = start; a_stop = stop; a_iv = init_valid; a_id = init_data;
    a_cv = cur_valid; a_cd = cur_data; a_uo = nrn_uo_out; a_uio = nrn_uio_out; a_oe = nrn_uio_oe;
    a_er = cfg_e_rest; a_et = cfg_e_tau; a_vt = cfg_v_th;
    @(posedge clk);
    #1;
    cyc++;
    e_rst = 1'b1; e_ui = 8'h00; e_uio = 8'h00; e_vv = 1'b0; e_vo = 16'h0000; e_spk = 1'b0;
    if (a_rst) begin
      act = 0; ierr = 0; cnt = 0;
    end else if (act && a_stop && rel >= T_RUN) begin
      act = 0;
    end else if (!act && a_start) begin
      act = 1; rel = 1; ierr = 0; cnt = 0;
      cfg_m[0] = a_er; cfg_m[1] = a_et; cfg_m[2] = a_vt;
    end else if (act) begin
      // Pins this cycle show what the previous cycle's state asked for.
      if (rel >= T_GAP) e_rst = 1'b0;
      if (rel >= T_PARAM && rel < T_SETUP) begin
        {e_ui, e_uio} = cfg_m[rel - T_PARAM];
      end else if (rel >= T_SETUP && rel < T_RUN) begin
        {e_ui, e_uio} = a_iv ? a_id : 16'h0000;
        if (!a_iv) ierr = 1;
      end else if (rel >= T_RUN) begin
        e_ui = a_cv ? a_cd : 8'h00;
      end
      if (rel < 100000) rel++;
      if (rel >= T_RUN + PIPE_LAT && a_oe[0]) begin
        e_vv = 1'b1;
        e_vo = {a_uo, a_uio[7:1], 1'b0};
        e_spk = a_uio[0];
        if (e_spk && cnt < CMAX) cnt++;
      end
    end
    chk("nrn_rst", 32'(nrn_rst), 32'(e_rst));
    chk("nrn_ui_in", 32'(nrn_ui_in), 32'(e_ui));
    chk("nrn_uio_in", 32'(nrn_uio_in), 32'(e_uio));
    chk("init_ready", 32'(init_ready), 32'(act && rel >= T_SETUP && rel < T_RUN));
    chk("cur_ready", 32'(cur_ready), 32'(act && rel >= T_RUN));
    chk("busy", 32'(busy), 32'(act));
    chk("init_err", 32'(init_err), 32'(ierr));
    chk("v_valid", 32'(v_valid), 32'(e_vv));
    chk("v_out", 32'(v_out), 32'(e_vo));
    chk("spike", 32'(spike), 32'(e_spk));
    chk("spike_count", 32'(spike_count), 32'(cnt));
    neuron(e_rst, e_ui, e_uio);
    drive();
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_e_rest = 16'h0000; cfg_e_tau = 16'h0000; cfg_v_th = 16'h0000;
    init_valid = 1'b0; init_data = 16'h0000; cur_valid = 1'b0; cur_data = 8'h00;
    nrn_uo_out = 8'h00; nrn_uio_out = 8'h00; nrn_uio_oe = 8'h00;
    n_cmp = 0; n_bad = 0; cyc = 0; act = 0; ierr = 0; rel = 0; cnt = 0;
    drop_idx = -1; force_ff = 0; kill_oe = 0; nw = 0;

    // Reset state
    tick();
    rst = 1'b1; tick();
    cycles(3);

    // Run A: reference config, clean init load, random currents
    cfg_e_rest = 16'hC400; cfg_e_tau = 16'h018E; cfg_v_th = 16'h3C00;
    start = 1'b1; tick();
    cycles(3);
    stop = 1'b1; tick();           // GAP: ignored
    cycles(20);
    start = 1'b1; tick();          // RUN: ignored
    cycles(60);
    kill_oe = 1; cycles(3); kill_oe = 0;
    cycles(60);
    stop = 1'b1; tick();
    cycles(3);

    // Run B: low threshold, full current, 4th init word dropped, saturation
    cfg_e_rest = 16'h0000; cfg_e_tau = 16'h0100; cfg_v_th = 16'h0100;
    drop_idx = 3; force_ff = 1;
    start = 1'b1; tick();
    cycles(120);
    stop = 1'b1; tick();
    cycles(3);

    // Run C: rst mid-PARAM, then a full replay
    drop_idx = -1; force_ff = 0;
    cfg_e_rest = 16'hC400; cfg_e_tau = 16'h018E; cfg_v_th = 16'h0800;
    start = 1'b1; tick();
    cycles(5);
    rst = 1'b1; tick();
    cycles(2);
    cfg_e_rest = 16'hC400; cfg_e_tau = 16'h018E; cfg_v_th = 16'h0800;
    start = 1'b1; tick();
    cycles(60);
    stop = 1'b1; tick();
    cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
